// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t m_hi;
    bcd_t m_lo;
    bcd_t s_hi;
    bcd_t s_lo;
    bcd_t cs_hi;
    bcd_t cs_lo;
  } stime_t;

  typedef struct packed {
    logic carry;
    bcd_t hi;
    bcd_t lo;
  } pair_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Limits held in BCD so they compare directly against a digit pair
  localparam logic [7:0] CS_MAX  = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;

  function automatic pair_t pair_inc(input bcd_t hi, input bcd_t lo, input logic [7:0] max);
    pair_t r;
    r.carry = 1'b0;
    r.hi    = hi;
    r.lo    = lo + 4'd1;
    if (lo == 4'd9) begin
      r.hi = hi + 4'd1;
      r.lo = '0;
    end
    if ({hi, lo} == max) begin
      r.carry = 1'b1;
      r.hi    = '0;
      r.lo    = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segments with a blank override.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  bcd_t       digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/digital_systems_top.sv
// MM:SS:CC stopwatch board top. Optional macro LEADING_ZERO_BLANK_EN blanks
// leading zero minute digits.
module digital_systems_top
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic        CLOCK_50,
  input  logic [4:0]  KEY,
  input  logic [9:0]  SW,
  output logic [10:0] LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic rst_n;
  assign rst_n = KEY[0];

  logic unused_inputs;
  assign unused_inputs = ^{KEY[4:3], SW[9:1]};

  logic [1:0] k_s1, k_s2, k_d;
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      k_s1 <= '1;
      k_s2 <= '1;
      k_d  <= '1;
    end else begin
      k_s1 <= KEY[2:1];
      k_s2 <= k_s1;
      k_d  <= k_s2;
    end
  end

  logic p1, p2;
  assign p1 = k_d[0] & ~k_s2[0];
  assign p2 = k_d[1] & ~k_s2[1] & ~p1;

  state_t state, next_state;
  logic   led_run, led_lap, led_wrap;
  logic   wrapped;
  stime_t cnt, lap_cap, disp;
  logic [PW-1:0] presc;
  logic   counting, tick, clear;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (p1) next_state = RUN;
      RUN:     if (p1) next_state = PAUSE; else if (p2) next_state = LAP;
      LAP:     if (p1) next_state = PAUSE; else if (p2) next_state = RUN;
      PAUSE:   if (p1) next_state = RUN;   else if (p2) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign clear    = p2 & ((state == IDLE) | (state == PAUSE));
  assign counting = (state == RUN) | (state == LAP);
  assign tick     = counting & (presc == PRESC_LAST);

  // Flags are registered from next_state so LEDR moves with the state register
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      led_run <= 1'b0;
      led_lap <= 1'b0;
      lap_cap <= '0;
    end else begin
      state   <= next_state;
      led_run <= (next_state == RUN) | (next_state == LAP);
      led_lap <= (next_state == LAP);
      if (state == RUN && next_state == LAP) lap_cap <= cnt;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear || state == IDLE) begin
      presc <= '0;
    end else if (counting) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  pair_t cs_n, s_n, m_n;
  always_comb begin
    cs_n = pair_inc(cnt.cs_hi, cnt.cs_lo, CS_MAX);
    s_n  = pair_inc(cnt.s_hi,  cnt.s_lo,  SEC_MAX);
    m_n  = pair_inc(cnt.m_hi,  cnt.m_lo,  MIN_MAX);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      wrapped <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      wrapped <= 1'b0;
    end else if (tick) begin
      cnt.cs_hi <= cs_n.hi;
      cnt.cs_lo <= cs_n.lo;
      if (cs_n.carry) begin
        cnt.s_hi <= s_n.hi;
        cnt.s_lo <= s_n.lo;
        if (s_n.carry) begin
          cnt.m_hi <= m_n.hi;
          cnt.m_lo <= m_n.lo;
          if (m_n.carry) wrapped <= 1'b1;
        end
      end
    end
  end

  assign disp = (state == LAP) ? lap_cap : cnt;

  logic blank_lo, blank_m_hi, blank_m_lo;
  assign blank_lo = SW[0];
`ifdef LEADING_ZERO_BLANK_EN
  assign blank_m_hi = SW[0] | (disp.m_hi == 4'd0);
  assign blank_m_lo = SW[0] | ((disp.m_hi == 4'd0) & (disp.m_lo == 4'd0));
`else
  assign blank_m_hi = SW[0];
  assign blank_m_lo = SW[0];
`endif

  logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5;
  seg7_decoder u_dec0 (.digit(disp.cs_lo), .blank(blank_lo),   .seg(seg0));
  seg7_decoder u_dec1 (.digit(disp.cs_hi), .blank(blank_lo),   .seg(seg1));
  seg7_decoder u_dec2 (.digit(disp.s_lo),  .blank(blank_lo),   .seg(seg2));
  seg7_decoder u_dec3 (.digit(disp.s_hi),  .blank(blank_lo),   .seg(seg3));
  seg7_decoder u_dec4 (.digit(disp.m_lo),  .blank(blank_m_lo), .seg(seg4));
  seg7_decoder u_dec5 (.digit(disp.m_hi),  .blank(blank_m_hi), .seg(seg5));

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      HEX0     <= SEG_0;
      HEX1     <= SEG_0;
      HEX2     <= SEG_0;
      HEX3     <= SEG_0;
`ifdef LEADING_ZERO_BLANK_EN
      HEX4     <= SEG_BLANK;
      HEX5     <= SEG_BLANK;
`else
      HEX4     <= SEG_0;
      HEX5     <= SEG_0;
`endif
      led_wrap <= 1'b0;
    end else begin
      HEX0     <= seg0;
      HEX1     <= seg1;
      HEX2     <= seg2;
      HEX3     <= seg3;
      HEX4     <= seg4;
      HEX5     <= seg5;
      led_wrap <= wrapped;
    end
  end

  assign LEDR = {8'b0, led_wrap, led_lap, led_run};

endmodule

// File: tb/tb_digital_systems_top.sv
// Directed bench for the stopwatch top with TICK_DIV=4.
module tb_digital_systems_top;

  logic        CLOCK_50 = 1'b0;
  logic [4:0]  KEY;
  logic [9:0]  SW;
  logic [10:0] LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [41:0] hex_all;

  int checks   = 0;
  int failures = 0;

  digital_systems_top #(.TICK_DIV(4)) dut (
    .CLOCK_50(CLOCK_50),
    .KEY(KEY),
    .SW(SW),
    .LEDR(LEDR),
    .HEX0(HEX0),
    .HEX1(HEX1),
    .HEX2(HEX2),
    .HEX3(HEX3),
    .HEX4(HEX4),
    .HEX5(HEX5)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] disp(input int mm, input int ss, input int cc);
    logic [6:0] h5, h4;
    h5 = seg(mm / 10);
    h4 = seg(mm % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (mm / 10 == 0) h5 = 7'h7F;
    if (mm == 0) h4 = 7'h7F;
`endif
    return {h5, h4, seg(ss / 10), seg(ss % 10), seg(cc / 10), seg(cc % 10)};
  endfunction

  task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // which[0] = KEY1, which[1] = KEY2; returns 6 cycles after the press starts
  task automatic press(input logic [1:0] which);
    KEY[1] = ~which[0];
    KEY[2] = ~which[1];
    repeat (3) @(negedge CLOCK_50);
    KEY[2:1] = 2'b11;
    repeat (3) @(negedge CLOCK_50);
  endtask

  initial begin
    KEY = 5'b00000;
    SW  = '0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_hex", hex_all, disp(0, 0, 0));
    check("reset_ledr", LEDR, 11'h000);

    KEY = 5'b11111;
    repeat (3) @(negedge CLOCK_50);
    press(2'b01);
    repeat (400) @(negedge CLOCK_50);
    check("run_1s_hex", hex_all, disp(0, 1, 0));
    check("run_1s_ledr", LEDR, 11'h001);

    press(2'b10);
    check("lap_ledr", LEDR, 11'h003);
    check("lap_hex", hex_all, disp(0, 1, 1));
    repeat (200) @(negedge CLOCK_50);
    check("lap_frozen_hex", hex_all, disp(0, 1, 1));

    // 50 ticks of hold plus two press latencies -> 52 ticks past the snapshot
    press(2'b10);
    check("lap_exit_hex", hex_all, disp(0, 1, 53));
    check("lap_exit_ledr", LEDR, 11'h001);

    press(2'b01);
    check("pause_hex", hex_all, disp(0, 1, 54));
    check("pause_ledr", LEDR, 11'h000);
    repeat (100) @(negedge CLOCK_50);
    check("pause_hold_hex", hex_all, disp(0, 1, 54));

    press(2'b10);
    check("clear_hex", hex_all, disp(0, 0, 0));
    check("clear_ledr", LEDR, 11'h000);

    force dut.cnt = 24'h59_59_98;
    @(negedge CLOCK_50);
    release dut.cnt;
    repeat (2) @(negedge CLOCK_50);
    check("preload_hex", hex_all, disp(59, 59, 98));

    press(2'b01);
    repeat (6) @(negedge CLOCK_50);
    check("wrap_hex", hex_all, disp(0, 0, 0));
    check("wrap_ledr", LEDR, 11'h005);

    SW[0] = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    check("blank_hex", hex_all, {6{7'h7F}});
    check("blank_ledr", LEDR, 11'h005);
    repeat (40) @(negedge CLOCK_50);
    SW[0] = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check("unblank_hex", hex_all, disp(0, 0, 11));

    press(2'b11);
    check("both_keys_ledr", LEDR, 11'h004);
    check("both_keys_hex", hex_all, disp(0, 0, 12));

    press(2'b10);
    check("clear_wrap_ledr", LEDR, 11'h000);
    check("clear_wrap_hex", hex_all, disp(0, 0, 0));

    press(2'b01);
    repeat (10) @(negedge CLOCK_50);
    KEY = 5'b00000;
    #1;
    check("async_reset_hex", hex_all, disp(0, 0, 0));
    check("async_reset_ledr", LEDR, 11'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
